// File: rtl/digit_gcd_arbiter.sv
// Two-requester round-robin front end sharing one subtraction-based GCD engine
// for decimal digits; returns the GCD and the owner's pair reduced by it.
module digit_gcd_arbiter #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [1:0] grant,
    output logic       busy,
    output logic [1:0] done,
    output logic [3:0] gcd_out,
    output logic [3:0] red_a,
    output logic [3:0] red_b
);

    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            rr_q, rr_d;         // index of the requester favoured on a tie
    logic            owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      x_q, x_d, y_q, y_d, sa_q, sa_d, sb_q, sb_d;
    logic [1:0]      grant_q, grant_d, done_q, done_d;
    logic            busy_q, busy_d;
    logic [3:0]      gcd_q, gcd_d, red_a_q, red_a_d, red_b_q, red_b_d;

    logic            win;
    logic            tick;
    logic            term;
    logic [3:0]      g;

    function automatic logic [3:0] mod10(input logic [3:0] v);
        mod10 = (v > 4'd9) ? v - 4'd10 : v;
    endfunction

    assign tick = (cnt_q == CNT_MAX);
    assign term = (x_q == 4'd0) || (y_q == 4'd0) || (x_q == y_q);
    assign g    = (x_q == 4'd0) ? y_q : x_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        done_d  = 2'b00;
        gcd_d   = gcd_q;
        red_a_d = red_a_q;
        red_b_d = red_b_q;
        win     = (req == 2'b11) ? rr_q : req[1];

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    owner_d = win;
                    sa_d    = mod10(win ? a1 : a0);
                    sb_d    = mod10(win ? b1 : b0);
                    x_d     = mod10(win ? a1 : a0);
                    y_d     = mod10(win ? b1 : b0);
                    cnt_d   = '0;
                    grant_d = win ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A dropped request outranks a terminating tick in the same cycle.
                if (!req[owner_q]) begin
                    cnt_d   = '0;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tick) begin
                    cnt_d = '0;
                    if (term) begin
                        done_d[owner_q] = 1'b1;
                        gcd_d   = g;
                        red_a_d = (g == 4'd0) ? 4'd0 : sa_q / g;
                        red_b_d = (g == 4'd0) ? 4'd0 : sb_q / g;
                        rr_d    = ~owner_q;
                        state_d = S_DONE;
                    end else if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        y_d = y_q - x_q;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 2'b00;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            sa_q    <= 4'd0;
            sb_q    <= 4'd0;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 2'b00;
            gcd_q   <= 4'd0;
            red_a_q <= 4'd0;
            red_b_q <= 4'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gcd_q   <= gcd_d;
            red_a_q <= red_a_d;
            red_b_q <= red_b_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign gcd_out = gcd_q;
    assign red_a   = red_a_q;
    assign red_b   = red_b_q;

endmodule

// File: tb/tb_digit_gcd_arbiter.sv
// Scoreboard bench for digit_gcd_arbiter: one full-speed instance and one at
// STEP_DIV=4 sharing operands, each with its own request lines.
module tb_digit_gcd_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, req4;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] grant, done, grant4, done4;
    logic       busy, busy4;
    logic [3:0] gcd_out, red_a, red_b, gcd4, red_a4, red_b4;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] owner;
        logic [3:0] g;
        logic [3:0] ra;
        logic [3:0] rb;
        int         lat;
    } exp_t;

    exp_t sb_q[$];

    logic [1:0] obs_done;
    logic [3:0] obs_g, obs_ra, obs_rb;

    always #5 clk = ~clk;

    digit_gcd_arbiter #(.STEP_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .grant(grant), .busy(busy), .done(done),
        .gcd_out(gcd_out), .red_a(red_a), .red_b(red_b)
    );

    digit_gcd_arbiter #(.STEP_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .grant(grant4), .busy(busy4), .done(done4),
        .gcd_out(gcd4), .red_a(red_a4), .red_b(red_b4)
    );

    // Reference: digits mod 10, GCD by divisor search, tick count by the
    // subtraction recurrence, latency k*step+1 from the acceptance cycle.
    function automatic exp_t model(input logic [1:0] owner, input logic [3:0] a,
                                   input logic [3:0] b, input int step);
        exp_t e;
        int x, y, g, k;
        x = int'(a) % 10;
        y = int'(b) % 10;
        if (x == 0) g = y;
        else if (y == 0) g = x;
        else begin
            g = 1;
            for (int d = 1; d <= 9; d++) if ((x % d == 0) && (y % d == 0)) g = d;
        end
        e.owner = owner;
        e.g  = 4'(g);
        e.ra = (g == 0) ? 4'd0 : 4'(x / g);
        e.rb = (g == 0) ? 4'd0 : 4'(y / g);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            k++;
            if (x == 0 || y == 0 || x == y) break;
            if (x > y) x -= y; else y -= x;
        end
        e.lat = k * step + 1;
        return e;
    endfunction

    // Waits for a done pulse on the full-speed instance, records what it saw
    // and drops the finishing requester's req in the done cycle.
    task automatic wait_done(input int budget, output int at);
        at = -1;
        obs_done = 2'b00;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done !== 2'b00) begin
                at = c;
                obs_done = done;
                obs_g = gcd_out;
                obs_ra = red_a;
                obs_rb = red_b;
                req = req & ~done;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        req4 = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b00; req4 = 2'b00;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, done, gcd_out, red_a, red_b} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", {grant, busy, done, gcd_out, red_a, red_b});
        end
        checks++;
        if ({grant4, busy4, done4, gcd4, red_a4, red_b4} !== 17'h0) begin
            failures++;
            $display("FAIL reset_outputs_div4: got %h want 0", {grant4, busy4, done4, gcd4, red_a4, red_b4});
        end
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_single();
        exp_t e;
        int at;
        @(negedge clk);
        a0 = 4'd6; b0 = 4'd4; req = 2'b01;
        sb_q.push_back(model(2'b01, a0, b0, 1));
        @(negedge clk);
        checks++;
        if ({grant, busy} !== 3'b011) begin
            failures++;
            $display("FAIL single_grant_c1: got %b want 011", {grant, busy});
        end
        wait_done(30, at);
        at += 1;
        e = sb_q.pop_front();
        checks++;
        if (at !== e.lat) begin
            failures++;
            $display("FAIL single_latency: got %0d want %0d", at, e.lat);
        end
        checks++;
        if ({obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
            failures++;
            $display("FAIL single_result: got %h want %h", {obs_done, obs_g, obs_ra, obs_rb}, {e.owner, e.g, e.ra, e.rb});
        end
        @(negedge clk);
        checks++;
        if ({grant, busy, done} !== 5'b0) begin
            failures++;
            $display("FAIL single_release: got %b want 00000", {grant, busy, done});
        end
        $display("single: done=%b at cycle %0d gcd=%0d red=%0d/%0d", obs_done, at, obs_g, obs_ra, obs_rb);
    endtask

    task automatic test_both_pending();
        exp_t e;
        int at;
        do_reset();
        @(negedge clk);
        a0 = 4'd5; b0 = 4'd3; a1 = 4'd9; b1 = 4'd0; req = 2'b11;
        sb_q.push_back(model(2'b01, a0, b0, 1));
        sb_q.push_back(model(2'b10, a1, b1, 1));
        wait_done(30, at);
        e = sb_q.pop_front();
        checks++;
        if (at !== e.lat || {obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
            failures++;
            $display("FAIL both_first: got at=%0d %h want at=%0d %h", at, {obs_done, obs_g, obs_ra, obs_rb}, e.lat, {e.owner, e.g, e.ra, e.rb});
        end
        $display("both: first done=%b at cycle %0d gcd=%0d red=%0d/%0d", obs_done, at, obs_g, obs_ra, obs_rb);
        wait_done(30, at);
        e = sb_q.pop_front();
        checks++;
        if (at !== e.lat + 1 || {obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
            failures++;
            $display("FAIL both_second: got at=%0d %h want at=%0d %h", at, {obs_done, obs_g, obs_ra, obs_rb}, e.lat + 1, {e.owner, e.g, e.ra, e.rb});
        end
        $display("both: second done=%b after %0d cycles gcd=%0d red=%0d/%0d", obs_done, at, obs_g, obs_ra, obs_rb);
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            failures++;
            $display("FAIL both_idle: got grant=%b want 00", grant);
        end
    endtask

    task automatic test_edges();
        exp_t e;
        int at;
        logic [3:0] pa [2];
        logic [3:0] pb [2];
        pa[0] = 4'd0; pb[0] = 4'd0;
        pa[1] = 4'd9; pb[1] = 4'd1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a0 = pa[i]; b0 = pb[i]; req = 2'b01;
            sb_q.push_back(model(2'b01, a0, b0, 1));
            wait_done(30, at);
            e = sb_q.pop_front();
            checks++;
            if (at !== e.lat) begin
                failures++;
                $display("FAIL edge%0d_latency: got %0d want %0d", i, at, e.lat);
            end
            checks++;
            if ({obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
                failures++;
                $display("FAIL edge%0d_result: got %h want %h", i, {obs_done, obs_g, obs_ra, obs_rb}, {e.owner, e.g, e.ra, e.rb});
            end
            $display("edge: pair (%0d,%0d) done at cycle %0d gcd=%0d red=%0d/%0d", pa[i], pb[i], at, obs_g, obs_ra, obs_rb);
            @(negedge clk);
        end
    endtask

    task automatic test_slow_step();
        exp_t e;
        int at;
        bit hold_ok;
        logic [1:0] d4;
        logic [3:0] g4, ra4, rb4;
        hold_ok = 1'b1;
        at = -1;
        d4 = 2'b00; g4 = 4'd0; ra4 = 4'd0; rb4 = 4'd0;
        @(negedge clk);
        a0 = 4'd6; b0 = 4'd4; req4 = 2'b01;
        sb_q.push_back(model(2'b01, a0, b0, 4));
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 3) a0 = 4'd9;
            if (grant4 !== 2'b01 || busy4 !== 1'b1) hold_ok = 1'b0;
            if (done4 !== 2'b00) begin
                at = c;
                d4 = done4; g4 = gcd4; ra4 = red_a4; rb4 = red_b4;
                req4 = 2'b00;
                break;
            end
        end
        e = sb_q.pop_front();
        checks++;
        if (at !== e.lat) begin
            failures++;
            $display("FAIL slow_latency: got %0d want %0d", at, e.lat);
        end
        checks++;
        if (!hold_ok) begin
            failures++;
            $display("FAIL slow_grant_busy: got a cycle without grant=01 busy=1 want held through done");
        end
        checks++;
        if ({d4, g4, ra4, rb4} !== {e.owner, e.g, e.ra, e.rb}) begin
            failures++;
            $display("FAIL slow_result: got %h want %h", {d4, g4, ra4, rb4}, {e.owner, e.g, e.ra, e.rb});
        end
        @(negedge clk);
        checks++;
        if ({grant4, busy4} !== 3'b000) begin
            failures++;
            $display("FAIL slow_release: got %b want 000", {grant4, busy4});
        end
        $display("slow: done=%b at cycle %0d gcd=%0d red=%0d/%0d", d4, at, g4, ra4, rb4);
    endtask

    task automatic test_abort();
        exp_t e;
        int at;
        bit quiet;
        @(negedge clk);
        a0 = 4'hC; b0 = 4'h8; req = 2'b01;
        sb_q.push_back(model(2'b01, a0, b0, 1));
        wait_done(30, at);
        e = sb_q.pop_front();
        checks++;
        if (at !== e.lat || {obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
            failures++;
            $display("FAIL mod10_result: got at=%0d %h want at=%0d %h", at, {obs_done, obs_g, obs_ra, obs_rb}, e.lat, {e.owner, e.g, e.ra, e.rb});
        end
        $display("mod10: done at cycle %0d gcd=%0d red=%0d/%0d", at, obs_g, obs_ra, obs_rb);
        @(negedge clk);
        @(negedge clk);
        a0 = 4'd3; b0 = 4'd7; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL abort_grant_c2: got %b want 01", grant);
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL abort_release_c3: got %b want 000", {grant, busy});
        end
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done !== 2'b00) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL abort_no_done: got a done pulse want none");
        end
        checks++;
        if ({gcd_out, red_a, red_b} !== {e.g, e.ra, e.rb}) begin
            failures++;
            $display("FAIL abort_hold: got %h want %h", {gcd_out, red_a, red_b}, {e.g, e.ra, e.rb});
        end
        $display("abort: outputs held gcd=%0d red=%0d/%0d", gcd_out, red_a, red_b);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int at;
        do_reset();
        @(negedge clk);
        a0 = 4'd8; b0 = 4'd6; a1 = 4'd3; b1 = 4'd9; req = 2'b11;
        sb_q.push_back(model(2'b01, a0, b0, 1));
        sb_q.push_back(model(2'b10, a1, b1, 1));
        for (int n = 0; n < 3; n++) begin
            wait_done(30, at);
            e = sb_q.pop_front();
            checks++;
            if (at < 0 || {obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
                failures++;
                $display("FAIL b2b_result%0d: got at=%0d %h want %h", n, at, {obs_done, obs_g, obs_ra, obs_rb}, {e.owner, e.g, e.ra, e.rb});
            end
            $display("b2b: transaction %0d done=%b gcd=%0d red=%0d/%0d", n, obs_done, obs_g, obs_ra, obs_rb);
            if (n == 0) begin
                @(negedge clk);
                req[0] = 1'b1;
                sb_q.push_back(model(2'b01, a0, b0, 1));
                @(negedge clk);
                checks++;
                if (grant !== 2'b10) begin
                    failures++;
                    $display("FAIL b2b_rr_grant: got %b want 10", grant);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int at;
        @(negedge clk);
        a0 = 4'd9; b0 = 4'd1; req = 2'b01;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        #1;
        checks++;
        if ({grant, busy, done, gcd_out, red_a, red_b} !== 17'h0) begin
            failures++;
            $display("FAIL reset_mid_async: got %h want 0", {grant, busy, done, gcd_out, red_a, red_b});
        end
        @(negedge clk);
        checks++;
        if (done !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_done: got %b want 00", done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        a0 = 4'd6; b0 = 4'd4; a1 = 4'd5; b1 = 4'd5; req = 2'b11;
        sb_q.push_back(model(2'b01, a0, b0, 1));
        sb_q.push_back(model(2'b10, a1, b1, 1));
        for (int n = 0; n < 2; n++) begin
            wait_done(30, at);
            e = sb_q.pop_front();
            checks++;
            if (at < 0 || {obs_done, obs_g, obs_ra, obs_rb} !== {e.owner, e.g, e.ra, e.rb}) begin
                failures++;
                $display("FAIL reset_mid_after%0d: got at=%0d %h want %h", n, at, {obs_done, obs_g, obs_ra, obs_rb}, {e.owner, e.g, e.ra, e.rb});
            end
            $display("reset_mid: transaction %0d done=%b gcd=%0d red=%0d/%0d", n, obs_done, obs_g, obs_ra, obs_rb);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_pending();
        test_edges();
        test_slow_step();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_gcd_arbiter.md
Name: digit_gcd_arbiter

Overview:
Shares a single iterative, subtraction-based GCD engine for decimal digits between two requesters, e.g. two digit-pair register banks of the board-level calculator modules. Requesters use a level req / pulse done handshake, and a round-robin arbiter grants the engine. The engine steps at a programmable rate, so the reduction can run at human-visible speed on the board or at full speed in simulation. On completion it returns the GCD and the owner's pair divided by it.

Parameters:
STEP_DIV, 1, clock cycles per engine step (1 = one step per cycle; 50_000_000 on the board)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  2  level request, bit i = requester i
a0  input  4  requester 0 operand A
b0  input  4  requester 0 operand B
a1  input  4  requester 1 operand A
b1  input  4  requester 1 operand B
grant  output  2  one-hot owner of the engine; 0 when idle
busy  output  1  engine in RUN or DONE
done  output  2  one-cycle completion pulse, bit = owner
gcd_out  output  4  last GCD result
red_a  output  4  last A / GCD
red_b  output  4  last B / GCD

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset sets state IDLE and rr pointer to favour requester 0. grant=0, busy=0, done=0, gcd_out=0, red_a=0, red_b=0. Step counter and working registers x, y, sa, sb are cleared.
- Operand capture: each operand is taken mod 10 at capture, so 4'hC becomes 2. Captured values sa, sb are saved for the final division. x=sa and y=sb.
- States: IDLE -> RUN -> DONE -> IDLE. A dropped req causes RUN -> IDLE.
- IDLE: if any req bit is high, pick a winner and capture its operands. The winner is the only requester if just one is high. If both are high, requester 0 wins when rr favours 0 (after reset, or after requester 1 was last served); otherwise requester 1. The next state is RUN. Step counter is set to 0. grant=one-hot owner from the next cycle.
- RUN: the step counter counts 0..STEP_DIV-1. A step tick occurs when the counter equals STEP_DIV-1, after which the counter wraps to 0. On a tick:
  - x==0 or y==0 or x==y: terminate. g = y if x==0, otherwise g = x. Next state DONE.
  - else if x>y: x=x-y.
  - else: y=y-x.
- Tick count: k = number of ticks including the terminating one. Maximum k is 9, for the pair (9,1).
- Latency: req is sampled in IDLE at cycle 0. RUN occupies cycles 1..k*STEP_DIV. done is high in cycle k*STEP_DIV+1.
- DONE (one cycle): done[owner]=1, gcd_out=g, red_a=sa/g, red_b=sb/g. If g==0 (input pair 0,0), red_a=red_b=0. The rr pointer moves to favour the non-owner. The next state is IDLE and grant returns to 0 in the following cycle.
- Output hold: gcd_out, red_a and red_b hold their values until the next DONE.
- Abort: if owner's req is low in any RUN cycle, the next state is IDLE. No done is issued, results are unchanged, and rr is unchanged.
- Non-owner requests: the non-owner's req is ignored while busy and stays pending, with no lost-request memory inside the block.
- Handshake rule: the requester must deassert req in the cycle done is high. A req seen high in IDLE is always a new request. If both are pending, the non-owner is served next.
- Operand stability: operands need only be valid in the IDLE acceptance cycle; later changes are ignored.
- Reset mid-operation: immediate return to reset values, with no done pulse.

Test Plan:
- STEP_DIV=1, req=01, a0=6, b0=4 -> grant=01 at cycle 1. Ticks (6,4)→(2,4)→(2,2)→term, so k=3. done=01 at cycle 4 with gcd_out=2, red_a=3, red_b=2. grant=0 at cycle 5.
- STEP_DIV=1, req=11 from reset, a0=5, b0=3, a1=9, b1=0 -> requester 0 served first: k=4, done=01 at cycle 5, gcd 1, red 5/3. Requester 1 is then accepted with k=1 and gets done=10 with gcd 9, red_a 1, red_b 0.
- Pairs (0,0) and (9,1), STEP_DIV=1 -> (0,0): done at cycle 2, gcd_out=0, red 0/0. (9,1): k=9, done at cycle 10, gcd 1, red 9/1.
- STEP_DIV=4, a0=6, b0=4 -> done at cycle 13 (3*4+1), with grant/busy high for cycles 1..13. Operand a0 changed during RUN does not affect the result.
- a0=4'hC, b0=4'h8 (captured 2, 8), and req dropped at cycle 2 on a repeat run -> the first run yields gcd 2, red 1/4. The aborted run gives no done, unchanged outputs, and grant=0 by cycle 3.
- rst_n asserted at cycle 2 of a run -> grant, busy, done and all results are 0 asynchronously. After release, requester 0 wins a simultaneous request.
